// File: rtl/prpg_bist_ctrl.sv
// BIST sequencer for one Nbit_PRPG: seeds and loads the PRPG, counts emitted patterns,
// and reports a result. Optional MISR signature compare is enabled by `PRPG_BIST_SIG_EN.
module prpg_bist_ctrl #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [N-1:0]     i_cfg_seed,
   input  logic [CNT_W-1:0] i_cfg_len,
   input  logic [N-1:0]     i_golden,
   input  logic [N-1:0]     i_cut_resp,
   output logic [N-1:0]     o_prpg_seed,
   output logic             o_prpg_reset,
   output logic             o_prpg_load,
   input  logic [N-1:0]     i_prpg_num,
   input  logic             i_prpg_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_seed_err,
   output logic [CNT_W-1:0] o_pat_cnt,
   output logic [N-1:0]     o_signature
);

   localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'((2 ** N) - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N-1:0]     r_seed;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_pat_cnt;
   logic [N-1:0]     r_sig;
   logic             r_pass;
   logic             r_seed_err;
   logic             r_done;
   logic             r_busy;
   logic             r_prpg_reset;
   logic             r_prpg_load;

   logic             w_start_ok;
   logic             w_seed_rej;
   logic             w_accept;
   logic             w_abort;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [N-1:0]     w_sig_nxt;
   logic             w_pass_nxt;

   // The PRPG pattern value itself is not needed; only its valid strobe is counted.
   logic w_unused;
   assign w_unused = ^{i_prpg_num, i_golden, i_cut_resp};

`ifdef PRPG_BIST_SIG_EN
   assign w_sig_nxt  = {r_sig[N-2:0], r_sig[N-1]} ^ i_cut_resp;
   assign w_pass_nxt = (r_sig == i_golden);
`else
   assign w_sig_nxt  = '0;
   assign w_pass_nxt = 1'b1;
`endif

   assign w_cnt_nxt = r_pat_cnt + CNT_W'(1);

   // Next-state and per-cycle event decode
   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_seed_rej  = 1'b0;
      w_accept    = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               if (i_cfg_seed != '0) begin
                  w_start_ok  = 1'b1;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_seed_rej = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (i_abort) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (i_abort) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (i_prpg_valid) begin
               w_accept = 1'b1;
               if (w_cnt_nxt == r_target) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_seed       <= '0;
         r_target     <= '0;
         r_pat_cnt    <= '0;
         r_sig        <= '0;
         r_pass       <= 1'b0;
         r_seed_err   <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_prpg_reset <= 1'b1;
         r_prpg_load  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prpg_reset <= (w_state_nxt == S_IDLE);
         r_prpg_load  <= (w_state_nxt == S_LOAD);
         r_busy       <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
         r_done       <= (w_state_nxt == S_DONE) || w_seed_rej;

         if (w_start_ok) begin
            r_seed     <= i_cfg_seed;
            r_target   <= (i_cfg_len == '0) ? FULL_LEN : i_cfg_len;
            r_pat_cnt  <= '0;
            r_sig      <= '0;
            r_pass     <= 1'b0;
            r_seed_err <= 1'b0;
         end
         if (w_seed_rej) begin
            r_seed_err <= 1'b1;
            r_pass     <= 1'b0;
         end
         if (w_accept) begin
            r_pat_cnt <= w_cnt_nxt;
            r_sig     <= w_sig_nxt;
         end
         if (w_abort) begin
            r_pass <= 1'b0;
         end
         if (r_state == S_DONE) begin
            r_pass <= w_pass_nxt;
         end
      end
   end

   assign o_prpg_seed  = r_seed;
   assign o_prpg_reset = r_prpg_reset;
   assign o_prpg_load  = r_prpg_load;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_seed_err   = r_seed_err;
   assign o_pat_cnt    = r_pat_cnt;
   assign o_signature  = r_sig;

endmodule

// File: tb/tb_prpg_bist_ctrl.sv
// Scoreboard bench for prpg_bist_ctrl: stimulus queues expected run results, a monitor
// checks them on each done pulse. Expectations follow `PRPG_BIST_SIG_EN when defined.
module tb_prpg_bist_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] cfg_seed = '0;
   logic [7:0] cfg_len = '0;
   logic [3:0] golden = '0;
   logic [3:0] cut_resp = '0;
   logic [3:0] prpg_num = '0;
   logic       prpg_valid = 1'b0;
   logic [3:0] o_prpg_seed;
   logic       o_prpg_reset;
   logic       o_prpg_load;
   logic       o_busy;
   logic       o_done;
   logic       o_pass;
   logic       o_seed_err;
   logic [7:0] o_pat_cnt;
   logic [3:0] o_signature;

   int n_chk = 0;
   int n_err = 0;
   int load_cnt = 0;

   typedef struct {
      logic [7:0] cnt;
      logic [3:0] sig;
      bit         pass;
      bit         serr;
      bit         chk_cnt;
   } exp_t;
   exp_t q[$];

   prpg_bist_ctrl #(.N(4), .CNT_W(8)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
      .i_cfg_seed(cfg_seed), .i_cfg_len(cfg_len), .i_golden(golden), .i_cut_resp(cut_resp),
      .o_prpg_seed(o_prpg_seed), .o_prpg_reset(o_prpg_reset), .o_prpg_load(o_prpg_load),
      .i_prpg_num(prpg_num), .i_prpg_valid(prpg_valid),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_seed_err(o_seed_err),
      .o_pat_cnt(o_pat_cnt), .o_signature(o_signature)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_prpg_load) load_cnt++;
      prpg_num <= prpg_num + 4'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] misr(input int n, input logic [3:0] resp);
      logic [3:0] s;
      s = '0;
`ifdef PRPG_BIST_SIG_EN
      for (int i = 0; i < n; i++) s = {s[2:0], s[3]} ^ resp;
`endif
      return s;
   endfunction

   function automatic bit exp_pass(input logic [3:0] sig, input logic [3:0] gold);
`ifdef PRPG_BIST_SIG_EN
      return sig == gold;
`else
      return 1'b1;
`endif
   endfunction

   // Monitor: pops one expectation per done pulse; pass is checked the cycle after
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_done) begin
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_done: got done=1 expected no done (pat_cnt=%0d)", o_pat_cnt);
            end else begin
               e = q.pop_front();
               chk("done_seed_err", 32'(o_seed_err), 32'(e.serr));
               chk("done_busy", 32'(o_busy), 32'd0);
               if (e.chk_cnt) begin
                  chk("done_pat_cnt", 32'(o_pat_cnt), 32'(e.cnt));
                  chk("done_signature", 32'(o_signature), 32'(e.sig));
               end
               @(negedge clk);
               chk("pass", 32'(o_pass), 32'(e.pass));
            end
         end
      end
   end

   task automatic run(input logic [3:0] seed, input logic [7:0] len, input bit toggle,
                      input logic [3:0] resp, input logic [3:0] gold, input int exp_cnt,
                      input bit hold_start);
      exp_t e;
      int   lc0;
      int   i;
      bit   got;
      e.cnt = 8'(exp_cnt);
      e.sig = misr(exp_cnt, resp);
      e.pass = exp_pass(e.sig, gold);
      e.serr = 1'b0;
      e.chk_cnt = 1'b1;
      q.push_back(e);
      lc0 = load_cnt;
      @(negedge clk);
      start = 1'b1; cfg_seed = seed; cfg_len = len; cut_resp = resp; golden = gold;
      @(negedge clk);
      start = hold_start;
      chk("load_pulse", 32'(o_prpg_load), 32'd1);
      chk("load_busy", 32'(o_busy), 32'd1);
      chk("load_prpg_reset", 32'(o_prpg_reset), 32'd0);
      chk("load_prpg_seed", 32'(o_prpg_seed), 32'(seed));
      i = 0;
      got = 1'b0;
      while (i < 200 && !got) begin
         @(negedge clk);
         if (o_done) got = 1'b1;
         else begin
            prpg_valid = toggle ? (i % 2 == 0) : 1'b1;
            i++;
         end
      end
      prpg_valid = 1'b0;
      start = 1'b0;
      if (!got) begin
         n_chk++;
         n_err++;
         $display("FAIL run_timeout: got no done in 200 cycles expected done (seed %0h)", seed);
      end
      chk("load_once", 32'(load_cnt - lc0), 32'd1);
   endtask

   initial begin
      exp_t e;
      int   lc0;
      // Reset with start held: no load may happen
      start = 1'b1; cfg_seed = 4'hF; cfg_len = 8'd5;
      repeat (3) @(negedge clk);
      chk("rst_prpg_reset", 32'(o_prpg_reset), 32'd1);
      chk("rst_prpg_load", 32'(o_prpg_load), 32'd0);
      chk("rst_prpg_seed", 32'(o_prpg_seed), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_pass", 32'(o_pass), 32'd0);
      chk("rst_seed_err", 32'(o_seed_err), 32'd0);
      chk("rst_pat_cnt", 32'(o_pat_cnt), 32'd0);
      chk("rst_signature", 32'(o_signature), 32'd0);
      chk("rst_no_load", 32'(load_cnt), 32'd0);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);

      run(4'hF, 8'd5, 1'b0, 4'h1, 4'h0, 5, 1'b0);
      chk("after_busy", 32'(o_busy), 32'd0);
      run(4'hA, 8'd3, 1'b0, 4'h1, 4'h7, 3, 1'b0);
      run(4'h6, 8'd3, 1'b0, 4'h1, 4'h6, 3, 1'b1);
      run(4'h1, 8'd0, 1'b0, 4'h2, 4'h0, 15, 1'b0);
      run(4'h9, 8'd0, 1'b1, 4'h1, 4'h0, 15, 1'b0);

      // Zero seed rejected
      e.cnt = '0; e.sig = '0; e.pass = 1'b0; e.serr = 1'b1; e.chk_cnt = 1'b0;
      q.push_back(e);
      lc0 = load_cnt;
      repeat (2) @(negedge clk);
      start = 1'b1; cfg_seed = 4'h0; cfg_len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      chk("zseed_busy", 32'(o_busy), 32'd0);
      chk("zseed_prpg_reset", 32'(o_prpg_reset), 32'd1);
      repeat (4) @(negedge clk);
      chk("zseed_no_load", 32'(load_cnt - lc0), 32'd0);
      chk("zseed_err_held", 32'(o_seed_err), 32'd1);

      // Abort after 2 of 5 patterns
      start = 1'b1; cfg_seed = 4'h5; cfg_len = 8'd5; cut_resp = 4'h3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      prpg_valid = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; prpg_valid = 1'b0;
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_prpg_reset", 32'(o_prpg_reset), 32'd1);
      chk("abort_pat_cnt", 32'(o_pat_cnt), 32'd2);
      chk("abort_signature", 32'(o_signature), 32'(misr(2, 4'h3)));
      chk("abort_pass", 32'(o_pass), 32'd0);
      @(negedge clk);
      chk("abort_pat_cnt_frozen", 32'(o_pat_cnt), 32'd2);

      // Start together with abort in IDLE is dropped
      lc0 = load_cnt;
      start = 1'b1; abort = 1'b1; cfg_seed = 4'h3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", 32'(o_busy), 32'd0);
      repeat (2) @(negedge clk);
      chk("sa_no_load", 32'(load_cnt - lc0), 32'd0);

      // Reset mid-run loses the run
      start = 1'b1; cfg_seed = 4'hC; cfg_len = 8'd10;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      prpg_valid = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; prpg_valid = 1'b0;
      chk("mrst_busy", 32'(o_busy), 32'd0);
      chk("mrst_pat_cnt", 32'(o_pat_cnt), 32'd0);
      chk("mrst_prpg_seed", 32'(o_prpg_seed), 32'd0);
      chk("mrst_prpg_reset", 32'(o_prpg_reset), 32'd1);

      run(4'h3, 8'd2, 1'b0, 4'h4, 4'h8, 2, 1'b0);

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
